// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator / duty-meter pair.
package pwm_pkg;
    localparam int PWM_CH     = 8;
    localparam int PWM_PERIOD = 101;
    localparam int PWM_CW     = 8;

    // Upstream generator duty settings, channel 0 in the low byte.
    localparam logic [PWM_CH-1:0][7:0] PWM_DUTY_TBL = {
        8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10
    };

    typedef enum logic {IDLE, SEND} meter_state_e;
endpackage

// File: rtl/pwm_chan_acc.sv
// One channel: registered PWM bit feeding a saturating high-cycle counter
// that restarts after each window end.
module pwm_chan_acc
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD,
    parameter int CW     = PWM_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pwm_i,
    input  logic          win_end_i,
    output logic [CW-1:0] sum_o
);
    logic          pwm_q;
    logic [CW-1:0] acc_q, acc_d;

    // sum_o includes the current cycle's sample, so it is the window result at window end.
    always_comb begin
        sum_o = acc_q;
        if (pwm_q && acc_q != CW'(PERIOD)) sum_o = acc_q + 1'b1;
        acc_d = win_end_i ? '0 : sum_o;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q <= 1'b0;
            acc_q <= '0;
        end else begin
            pwm_q <= pwm_i;
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/pwm_duty_meter.sv
// Measures per-channel PWM duty over a fixed window and streams the results
// out one channel per valid/ready beat.
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int CH     = PWM_CH,
    parameter int PERIOD = PWM_PERIOD,
    parameter int CW     = PWM_CW,
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [CH-1:0]  pwm_in,
    input  logic           clear_ovf,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [CW-1:0]  out_duty,
    output logic           overrun
);
    localparam int WW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [WW-1:0]         win_cnt_q, win_cnt_d;
    logic                  win_end;
    logic [CH-1:0][CW-1:0] sum;
    logic [CH-1:0][CW-1:0] bank_q, bank_d;
    meter_state_e          state_q, state_d;
    logic [CHW-1:0]        out_ch_q, out_ch_d;
    logic                  overrun_q, overrun_d;
    logic                  hs, last, bank_free, load;

    assign win_end   = (win_cnt_q == WW'(PERIOD - 1));
    assign win_cnt_d = win_end ? '0 : win_cnt_q + 1'b1;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        pwm_chan_acc #(.PERIOD(PERIOD), .CW(CW)) u_acc (
            .clk       (clk),
            .reset     (reset),
            .pwm_i     (pwm_in[c]),
            .win_end_i (win_end),
            .sum_o     (sum[c])
        );
    end

    // The bank may be reloaded in the same cycle its last beat is accepted.
    always_comb begin
        hs        = (state_q == SEND) && out_ready;
        last      = (out_ch_q == CHW'(CH - 1));
        bank_free = (state_q == IDLE) || (hs && last);
        load      = win_end && bank_free;

        state_d   = state_q;
        out_ch_d  = out_ch_q;
        bank_d    = bank_q;
        overrun_d = overrun_q;

        if (hs) begin
            if (last) begin
                state_d  = IDLE;
                out_ch_d = '0;
            end else begin
                out_ch_d = out_ch_q + 1'b1;
            end
        end
        if (load) begin
            bank_d   = sum;
            state_d  = SEND;
            out_ch_d = '0;
        end

        if (clear_ovf) overrun_d = 1'b0;
        if (win_end && !bank_free) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt_q <= '0;
            bank_q    <= '0;
            state_q   <= IDLE;
            out_ch_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            bank_q    <= bank_d;
            state_q   <= state_d;
            out_ch_q  <= out_ch_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_ch    = out_ch_q;
    assign out_duty  = bank_q[out_ch_q];
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomized bench for pwm_duty_meter against a window/queue reference model.
module tb_pwm_duty_meter;
    import pwm_pkg::*;

    localparam int CH     = 8;
    localparam int PERIOD = 101;
    localparam int CW     = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] pwm_in;
    logic          clear_ovf;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_ch;
    logic [CW-1:0] out_duty;
    logic          overrun;

    pwm_duty_meter #(.CH(CH), .PERIOD(PERIOD), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .clear_ovf (clear_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_duty  (out_duty),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int duty;
    } beat_t;

    // Reference model: pending beats, samples of the current window, sticky flag.
    beat_t         m_beats[$];
    logic [CH-1:0] m_win[$];
    logic [CH-1:0] m_pwmq;
    bit            m_ovf;
    int            m_pos;

    int n_vec = 0;
    int n_err = 0;
    int exp_mode = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_beats.delete();
        m_win.delete();
        m_pwmq = '0;
        m_ovf  = 1'b0;
        m_pos  = 0;
    endtask

    // Check the current cycle at negedge, advance the model, then move past the next posedge.
    task automatic step();
        int  e;
        int  cnt;
        bit  nxt_ovf;
        beat_t b;
        @(negedge clk);
        chk("valid", out_valid, m_beats.size() != 0);
        chk("overrun", overrun, m_ovf);
        if (m_beats.size() != 0) begin
            chk("ch", out_ch, m_beats[0].ch);
            chk("duty", out_duty, m_beats[0].duty);
            if (exp_mode != 0) begin
                case (exp_mode)
                    1:       e = PERIOD;
                    2:       e = (m_beats[0].ch + 1) * 10;
                    default: e = (m_beats[0].ch < 4) ? PERIOD : 0;
                endcase
                chk("duty_ref", out_duty, e);
            end
        end

        m_win.push_back(m_pwmq);
        if (m_beats.size() != 0 && out_ready) void'(m_beats.pop_front());
        nxt_ovf = clear_ovf ? 1'b0 : m_ovf;
        if (m_pos == PERIOD - 1) begin
            if (m_beats.size() == 0) begin
                for (int c = 0; c < CH; c++) begin
                    cnt = 0;
                    foreach (m_win[i]) cnt += m_win[i][c];
                    if (cnt > PERIOD) cnt = PERIOD;
                    b.ch = c;
                    b.duty = cnt;
                    m_beats.push_back(b);
                end
            end else begin
                nxt_ovf = 1'b1;
            end
            m_win.delete();
        end
        m_ovf  = nxt_ovf;
        m_pwmq = pwm_in;
        m_pos  = (m_pos + 1) % PERIOD;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [CH-1:0] gen_pwm(input int pos);
        logic [CH-1:0] v;
        int gcnt;
        gcnt = (pos + 1) % PERIOD;
        for (int c = 0; c < CH; c++) v[c] = (gcnt < PWM_DUTY_TBL[c]);
        return v;
    endfunction

    initial begin
        int guard;
        reset     = 1'b1;
        pwm_in    = '0;
        clear_ovf = 1'b0;
        out_ready = 1'b0;
        #1;
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_duty", out_duty, 0);
        chk("rst_ovf", overrun, 0);

        // Constant high input, always ready: full-window counts.
        pwm_in    = '1;
        out_ready = 1'b1;
        repeat (PERIOD + 8) step();
        exp_mode = 1;
        repeat (3 * PERIOD) step();
        exp_mode = 0;

        // Upstream generator with the duty table.
        for (int n = 0; n < 2 * PERIOD; n++) begin
            pwm_in = gen_pwm(m_pos);
            step();
        end
        exp_mode = 2;
        for (int n = 0; n < 2 * PERIOD; n++) begin
            pwm_in = gen_pwm(m_pos);
            step();
        end
        exp_mode = 0;

        // Last handshake lands on the window-end cycle.
        while (m_pos != 0) begin pwm_in = CH'($urandom); step(); end
        out_ready = 1'b0;
        while (m_pos != PERIOD - 8) begin pwm_in = CH'($urandom); step(); end
        out_ready = 1'b1;
        while (m_pos != 0) begin pwm_in = CH'($urandom); step(); end
        chk("wend_ovf", overrun, 0);
        chk("wend_valid", out_valid, 1);
        chk("wend_ch", out_ch, 0);

        // Reset in the middle of a send.
        repeat (3) step();
        chk("mid_ch", out_ch, 3);
        do_reset();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ch", out_ch, 0);
        chk("mrst_ovf", overrun, 0);
        pwm_in = '1;
        repeat (PERIOD) step();
        chk("first_win_valid", out_valid, 1);

        // Long stall: second window end overruns, bank keeps the first window.
        pwm_in = 8'h0F;
        repeat (PERIOD + 8) step();
        out_ready = 1'b0;
        repeat (250) step();
        chk("stall_ovf", overrun, 1);
        out_ready = 1'b1;
        exp_mode = 3;
        repeat (8) step();
        exp_mode = 0;

        // Clear with no new overrun.
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("clr_ovf", overrun, 0);

        // Clear coincident with an overrun event.
        out_ready = 1'b0;
        guard = 0;
        while (!(m_pos == PERIOD - 1 && m_ovf) && guard < 4 * PERIOD) begin
            step();
            guard++;
        end
        chk("ovf_wait_guard", guard < 4 * PERIOD, 1);
        chk("pre_clr_ovf", overrun, 1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("clr_vs_set", overrun, 1);
        out_ready = 1'b1;

        // Random traffic with a reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            pwm_in    = CH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clear_ovf = ($urandom_range(0, 30) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
